seq_chunk_adder: RTL and testbench

- Multi-cycle, parametrised successor to the fixed 5-bit ripple adder partitions.
- Adds two WIDTH-bit operands one CHUNK-bit slice per clock, carrying between slices through a carry register.
- Supports a runtime-selectable approximate mode: segmented carry plus a lower-part OR adder.
- Sits behind a valid/ready handshake so approximate-arithmetic experiments can drop it into pipelined datapaths and compare exact and approximate results in the same run.

---
 rtl/seq_chunk_adder_pkg.sv | 25 ++
 rtl/seq_chunk_adder_adder_chunk.sv | 42 ++++
 rtl/seq_chunk_adder.sv | 145 ++++++++++++++
 tb/tb_seq_chunk_adder.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and sizing helpers for the sequential chunked adder.
// The top level and its slice adder both import this package.
package seq_chunk_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    function automatic int calc_nch(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A slice counter is never narrower than one bit, even for a single slice.
    function automatic int calc_idx_w(input int width, input int chunk);
        int r;
        r = $clog2(width / chunk);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seq_chunk_adder_adder_chunk.sv
// Combinational CHUNK-bit slice adder. When or_en is set, the low LSB_OR
// bits become a|b and the carry into the upper part is a[L-1]&b[L-1].
module adder_chunk
    import seq_chunk_adder_pkg::*;
#(
    parameter int CHUNK  = 5,
    parameter int LSB_OR = 0
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    input  logic             or_en,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0]   exact_full;
    logic [CHUNK-1:0] or_sum;
    logic             or_cout;

    assign exact_full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

    generate
        if (LSB_OR == 0) begin : g_no_or
            assign or_sum  = exact_full[CHUNK-1:0];
            assign or_cout = exact_full[CHUNK];
        end else if (LSB_OR == CHUNK) begin : g_full_or
            assign or_sum  = a | b;
            assign or_cout = a[CHUNK-1] & b[CHUNK-1];
        end else begin : g_part_or
            logic [CHUNK-LSB_OR:0] hi_full;
            assign hi_full = {1'b0, a[CHUNK-1:LSB_OR]} + {1'b0, b[CHUNK-1:LSB_OR]}
                           + {{(CHUNK-LSB_OR){1'b0}}, a[LSB_OR-1] & b[LSB_OR-1]};
            assign or_sum  = {hi_full[CHUNK-LSB_OR-1:0], a[LSB_OR-1:0] | b[LSB_OR-1:0]};
            assign or_cout = hi_full[CHUNK-LSB_OR];
        end
    endgenerate

    assign sum  = or_en ? or_sum  : exact_full[CHUNK-1:0];
    assign cout = or_en ? or_cout : exact_full[CHUNK];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: one CHUNK-bit slice per clock behind valid/ready, with a
// runtime approximate mode (segmented carry plus lower-part OR on slice 0).
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH      = 20,
    parameter int CHUNK      = 5,
    parameter int APPROX_LSB = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_approx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int NCH  = calc_nch(WIDTH, CHUNK);
    localparam int IDXW = calc_idx_w(WIDTH, CHUNK);

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_width
            $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
        end
        if ((APPROX_LSB < 0) || (APPROX_LSB > CHUNK)) begin : g_bad_lsb
            $error("seq_chunk_adder: APPROX_LSB must lie in 0..CHUNK");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              approx_q, approx_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic [IDXW-1:0]   idx_q, idx_d;

    logic [CHUNK-1:0]  a_sl [NCH];
    logic [CHUNK-1:0]  b_sl [NCH];
    logic [CHUNK-1:0]  ch_sum;
    logic              ch_cout;
    logic              or_en;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_slice
            assign a_sl[gi] = a_q[gi*CHUNK +: CHUNK];
            assign b_sl[gi] = b_q[gi*CHUNK +: CHUNK];
        end
    endgenerate

    // Only slice 0 of an approximate operation takes the OR lower part.
    assign or_en = (approx_q == MODE_APPROX) && (idx_q == '0);

    adder_chunk #(
        .CHUNK  (CHUNK),
        .LSB_OR (APPROX_LSB)
    ) u_chunk (
        .a     (a_sl[idx_q]),
        .b     (b_sl[idx_q]),
        .cin   (carry_q),
        .or_en (or_en),
        .sum   (ch_sum),
        .cout  (ch_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        approx_d = approx_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        idx_d    = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d      = in_a;
                    b_d      = in_b;
                    approx_d = in_approx;
                    sum_d    = '0;
                    cout_d   = 1'b0;
                    idx_d    = '0;
                    carry_d  = ((in_approx == MODE_APPROX) && (APPROX_LSB > 0)) ? 1'b0 : in_cin;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[idx_q*CHUNK +: CHUNK] = ch_sum;
                carry_d = (approx_q == MODE_APPROX) ? 1'b0 : ch_cout;
                if (idx_q == IDXW'(NCH - 1)) begin
                    cout_d  = ch_cout;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            approx_q <= MODE_EXACT;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            approx_q <= approx_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            idx_q    <= idx_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder: two instances (APPROX_LSB 0 and 3)
// share one stimulus stream and are checked against an independent model.
module tb_seq_chunk_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [19:0] in_a, in_b;
    logic        in_cin, in_approx;
    logic        out_ready;

    logic        in_ready0, out_valid0, out_cout0, busy0;
    logic [19:0] out_sum0;
    logic        in_ready3, out_valid3, out_cout3, busy3;
    logic [19:0] out_sum3;

    logic [20:0] exp0_q [$];
    logic [20:0] exp3_q [$];

    int tests = 0;
    int fails = 0;
    int txn   = 0;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(20), .CHUNK(5), .APPROX_LSB(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_approx(in_approx),
        .out_valid(out_valid0), .out_ready(out_ready), .out_sum(out_sum0),
        .out_cout(out_cout0), .busy(busy0)
    );

    seq_chunk_adder #(.WIDTH(20), .CHUNK(5), .APPROX_LSB(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_approx(in_approx),
        .out_valid(out_valid3), .out_ready(out_ready), .out_sum(out_sum3),
        .out_cout(out_cout3), .busy(busy3)
    );

    // Golden model returning {cout, sum}.
    function automatic logic [20:0] model(input logic [19:0] a, input logic [19:0] b,
                                          input logic cin, input logic approx, input int l);
        int unsigned ai, bi, res, co, as, bs, t, hi, lowm, cl, slice;
        ai = 32'(a);
        bi = 32'(b);
        if (!approx) begin
            t = ai + bi + 32'(cin);
            return 21'(t);
        end
        res = 0;
        co  = 0;
        for (int s = 0; s < 4; s++) begin
            as = (ai >> (5 * s)) & 31;
            bs = (bi >> (5 * s)) & 31;
            if (s == 0 && l > 0) begin
                lowm  = (1 << l) - 1;
                cl    = (as >> (l - 1)) & (bs >> (l - 1)) & 1;
                hi    = (as >> l) + (bs >> l) + cl;
                slice = ((as | bs) & lowm) | ((hi << l) & 31);
                co    = (hi << l) >> 5;
            end else begin
                t     = as + bs + ((s == 0) ? 32'(cin) : 0);
                slice = t & 31;
                co    = t >> 5;
            end
            res = res | (slice << (5 * s));
        end
        return {co[0], res[19:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pushes the expected results, then holds in_valid until accepted and
    // scrambles the inputs afterwards so late sampling would be visible.
    task automatic send(input logic [19:0] a, input logic [19:0] b,
                        input logic cin, input logic approx);
        exp0_q.push_back(model(a, b, cin, approx, 0));
        exp3_q.push_back(model(a, b, cin, approx, 3));
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_approx = approx;
        in_valid  = 1'b1;
        for (int i = 0; i < 40 && !in_ready0; i++) step();
        step();
        in_valid  = 1'b0;
        in_a      = 20'($urandom);
        in_b      = 20'($urandom);
        in_cin    = 1'($urandom_range(0, 1));
        in_approx = ~approx;
        txn++;
        $display("[TB] txn %0d a=%05h b=%05h cin=%0b approx=%0b", txn, a, b, cin, approx);
    endtask

    task automatic wait_result(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid0 && out_valid3) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_approx = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        tests++;
        if ({in_ready0, out_valid0, busy0, out_cout0, out_sum0} !== {3'b100, 21'h0}) begin
            fails++;
            $display("FAIL reset_dut0 got rdy=%0b vld=%0b busy=%0b cout=%0b sum=%05h want 1 0 0 0 00000",
                     in_ready0, out_valid0, busy0, out_cout0, out_sum0);
        end
        tests++;
        if ({in_ready3, out_valid3, busy3, out_cout3, out_sum3} !== {3'b100, 21'h0}) begin
            fails++;
            $display("FAIL reset_dut3 got rdy=%0b vld=%0b busy=%0b cout=%0b sum=%05h want 1 0 0 0 00000",
                     in_ready3, out_valid3, busy3, out_cout3, out_sum3);
        end
    endtask

    task automatic test_exact_ripple();
        logic [20:0] e0, e3;
        out_ready = 1'b1;
        send(20'hFFFFF, 20'h00001, 1'b0, 1'b0);
        step(); step(); step();
        tests++;
        if ({out_valid0, busy0} !== 2'b01) begin
            fails++;
            $display("FAIL latency_early got vld=%0b busy=%0b want vld=0 busy=1", out_valid0, busy0);
        end
        step();
        tests++;
        if (out_valid0 !== 1'b1) begin
            fails++;
            $display("FAIL latency_edge got vld=%0b want 1 at E+4", out_valid0);
        end
        e0 = exp0_q.pop_front();
        e3 = exp3_q.pop_front();
        tests++;
        if ({out_cout0, out_sum0} !== e0) begin
            fails++;
            $display("FAIL exact_ripple_dut0 got %06h want %06h", {out_cout0, out_sum0}, e0);
        end
        tests++;
        if ({out_cout3, out_sum3} !== e3) begin
            fails++;
            $display("FAIL exact_ripple_dut3 got %06h want %06h", {out_cout3, out_sum3}, e3);
        end
        tests++;
        if ({out_cout0, out_sum0} !== 21'h100000) begin
            fails++;
            $display("FAIL exact_ripple_const got %06h want 100000", {out_cout0, out_sum0});
        end
        step();
        tests++;
        if ({out_valid0, in_ready0} !== 2'b01) begin
            fails++;
            $display("FAIL handshake_release got vld=%0b rdy=%0b want 0 1", out_valid0, in_ready0);
        end
    endtask

    task automatic test_approx_modes();
        logic [20:0] e0, e3;
        logic [20:0] want0 [3];
        logic [20:0] want3 [3];
        logic [19:0] ta [3];
        logic [19:0] tbv [3];
        logic        tap [3];
        bit ok;
        ta[0] = 20'hFFFFF; tbv[0] = 20'h00001; tap[0] = 1'b1; want0[0] = 21'h0FFFE0; want3[0] = 21'h0FFFFF;
        ta[1] = 20'h00007; tbv[1] = 20'h00001; tap[1] = 1'b1; want0[1] = 21'h000008; want3[1] = 21'h000007;
        ta[2] = 20'h00007; tbv[2] = 20'h00001; tap[2] = 1'b0; want0[2] = 21'h000008; want3[2] = 21'h000008;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send(ta[k], tbv[k], 1'b0, tap[k]);
            wait_result(ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL approx_timeout case %0d got no out_valid want out_valid", k);
            end
            e0 = exp0_q.pop_front();
            e3 = exp3_q.pop_front();
            tests++;
            if ({out_cout0, out_sum0} !== e0 || e0 !== want0[k]) begin
                fails++;
                $display("FAIL approx_dut0 case %0d got %06h want %06h", k, {out_cout0, out_sum0}, want0[k]);
            end
            tests++;
            if ({out_cout3, out_sum3} !== e3 || e3 !== want3[k]) begin
                fails++;
                $display("FAIL approx_dut3 case %0d got %06h want %06h", k, {out_cout3, out_sum3}, want3[k]);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [20:0] e0, e3;
        bit ok;
        out_ready = 1'b0;
        send(20'h12345, 20'h01111, 1'b1, 1'b0);
        wait_result(ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL bp_timeout got no out_valid want out_valid");
        end
        e0 = exp0_q.pop_front();
        e3 = exp3_q.pop_front();
        tests++;
        if ({out_cout0, out_sum0} !== 21'h013457 || e0 !== 21'h013457) begin
            fails++;
            $display("FAIL bp_sum got %06h want 013457", {out_cout0, out_sum0});
        end
        for (int k = 0; k < 5; k++) begin
            tests++;
            if ({out_valid0, in_ready0, out_cout0, out_sum0} !== {2'b10, e0} ||
                {out_valid3, in_ready3, out_cout3, out_sum3} !== {2'b10, e3}) begin
                fails++;
                $display("FAIL bp_hold cycle %0d got vld=%0b rdy=%0b %06h want 1 0 %06h",
                         k, out_valid0, in_ready0, {out_cout0, out_sum0}, e0);
            end
            if (k == 0) begin
                in_a = 20'h00001; in_b = 20'h00001; in_cin = 1'b0; in_approx = 1'b0;
                in_valid = 1'b1;
                exp0_q.push_back(model(20'h00001, 20'h00001, 1'b0, 1'b0, 0));
                exp3_q.push_back(model(20'h00001, 20'h00001, 1'b0, 1'b0, 3));
            end
            step();
        end
        out_ready = 1'b1;
        step();
        tests++;
        if ({out_valid0, in_ready0} !== 2'b01) begin
            fails++;
            $display("FAIL bp_release got vld=%0b rdy=%0b want 0 1", out_valid0, in_ready0);
        end
        step();
        in_valid = 1'b0;
        tests++;
        if (busy0 !== 1'b1) begin
            fails++;
            $display("FAIL bp_accept got busy=%0b want 1", busy0);
        end
        wait_result(ok);
        e0 = exp0_q.pop_front();
        e3 = exp3_q.pop_front();
        tests++;
        if (!ok || {out_cout0, out_sum0} !== e0 || {out_cout3, out_sum3} !== e3) begin
            fails++;
            $display("FAIL bp_second got %06h want %06h", {out_cout0, out_sum0}, e0);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        logic [20:0] e0, e3;
        bit ok;
        out_ready = 1'b1;
        in_a = 20'h0F0F0; in_b = 20'h00F0F; in_cin = 1'b0; in_approx = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if ({out_valid0, in_ready0, out_sum0} !== {2'b01, 20'h0} ||
            {out_valid3, in_ready3, out_sum3} !== {2'b01, 20'h0}) begin
            fails++;
            $display("FAIL mid_reset got vld=%0b rdy=%0b sum=%05h want 0 1 00000",
                     out_valid0, in_ready0, out_sum0);
        end
        send(20'h00001, 20'h00001, 1'b0, 1'b0);
        wait_result(ok);
        e0 = exp0_q.pop_front();
        e3 = exp3_q.pop_front();
        tests++;
        if (!ok || {out_cout0, out_sum0} !== 21'h000002 || {out_cout3, out_sum3} !== e3) begin
            fails++;
            $display("FAIL mid_reset_fresh got %06h want %06h", {out_cout0, out_sum0}, e0);
        end
        step();
    endtask

    task automatic test_random();
        logic [20:0] e0, e3;
        bit ok;
        int n;
        out_ready = 1'b0;
        for (int it = 0; it < 2000; it++) begin
            send(20'($urandom), 20'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_result(ok);
            e0 = exp0_q.pop_front();
            e3 = exp3_q.pop_front();
            tests++;
            if (!ok || {out_cout0, out_sum0} !== e0 || {out_cout3, out_sum3} !== e3) begin
                fails++;
                $display("FAIL random it %0d got %06h/%06h want %06h/%06h",
                         it, {out_cout0, out_sum0}, {out_cout3, out_sum3}, e0, e3);
            end
            n = $urandom_range(0, 2);
            for (int s = 0; s < n; s++) begin
                step();
                tests++;
                if (!out_valid0 || {out_cout0, out_sum0} !== e0) begin
                    fails++;
                    $display("FAIL random_stall it %0d got vld=%0b %06h want 1 %06h",
                             it, out_valid0, {out_cout0, out_sum0}, e0);
                end
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_exact_ripple();
        test_approx_modes();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
